// File: rtl/state_machine_pkg.sv
// Shared encodings for the multicycle control FSM: states, instruction
// classes, opcode/ext fields, ALU operation codes and mux select codes.
package state_machine_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      WB     = 3'd3,
      MEM_RD = 3'd4,
      LD_WB  = 3'd5,
      MEM_WR = 3'd6
   } stateType;

   typedef enum logic [2:0] {
      CLASS_NOP     = 3'd0,
      CLASS_ALU_REG = 3'd1,
      CLASS_ALU_IMM = 3'd2,
      CLASS_SHIFT   = 3'd3,
      CLASS_LOAD    = 3'd4,
      CLASS_STORE   = 3'd5
   } instrClassType;

   // Opcode field [15:12]. Opcode 0010 is shared by the memory ops and ORI.
   localparam logic [3:0] OP_REG   = 4'b0000;
   localparam logic [3:0] OP_ANDI  = 4'b0001;
   localparam logic [3:0] OP_MEM   = 4'b0010;
   localparam logic [3:0] OP_XORI  = 4'b0011;
   localparam logic [3:0] OP_ADDI  = 4'b0101;
   localparam logic [3:0] OP_SHIFT = 4'b1000;
   localparam logic [3:0] OP_SUBI  = 4'b1001;
   localparam logic [3:0] OP_CMPI  = 4'b1011;
   localparam logic [3:0] OP_MOVI  = 4'b1101;

   // Ext field [7:4] for register ALU ops, shifts and memory ops.
   localparam logic [3:0] EXT_AND      = 4'b0001;
   localparam logic [3:0] EXT_OR       = 4'b0010;
   localparam logic [3:0] EXT_XOR      = 4'b0011;
   localparam logic [3:0] EXT_ADD      = 4'b0101;
   localparam logic [3:0] EXT_SUB      = 4'b1001;
   localparam logic [3:0] EXT_CMP      = 4'b1011;
   localparam logic [3:0] EXT_MOV      = 4'b1101;
   localparam logic [3:0] EXT_LSH      = 4'b0100;
   localparam logic [3:0] EXT_LSHI     = 4'b0000;
   localparam logic [3:0] EXT_LSHI_ALT = 4'b0001;
   localparam logic [3:0] EXT_LOAD     = 4'b0000;
   localparam logic [3:0] EXT_STORE    = 4'b0100;

   // ALU operation codes driven on aluControl.
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_CMP = 4'b0101;
   localparam logic [3:0] ALU_MOV = 4'b0110;
   localparam logic [3:0] ALU_LSH = 4'b0111;

   // Two-bit enables: only 01 means "on".
   localparam logic [1:0] EN_OFF = 2'b00;
   localparam logic [1:0] EN_ON  = 2'b01;

   // Mux select codes.
   localparam logic [1:0] ADDR_PC   = 2'b00;
   localparam logic [1:0] ADDR_SRC  = 2'b01;
   localparam logic [1:0] WB_RESULT = 2'b00;
   localparam logic [1:0] WB_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU   = 2'b00;
   localparam logic [1:0] RES_SHIFT = 2'b01;
   localparam logic [1:0] B_SRC     = 2'b00;
   localparam logic [1:0] B_IMM     = 2'b01;

   // Turns a condition into a two-bit enable code.
   function automatic logic [1:0] enIf(input logic cond);
      return cond ? EN_ON : EN_OFF;
   endfunction

endpackage

// File: rtl/state_machine_decode.sv
// Combinational instruction decoder: classifies the instruction register and
// derives the ALU operation plus immediate, sign-extend and shift flags.
module instr_decode
   import state_machine_pkg::*;
(
   input  logic [15:0]   ir,
   output instrClassType instrClass,
   output logic [3:0]    aluOp,
   output logic          immFlag,
   output logic          signFlag,
   output logic          shiftFlag
);

   logic [3:0] opcode;
   logic [3:0] ext;
   logic       unusedRegFields;

   assign opcode          = ir[15:12];
   assign ext             = ir[7:4];
   assign unusedRegFields = ^{ir[11:8], ir[3:0]};

   // Decode opcode/ext into a class; anything unrecognised falls to NOP.
   // On opcode 0010 the memory ext codes win, every other ext is ORI.
   always_comb begin
      instrClass = CLASS_NOP;
      aluOp      = ALU_ADD;
      immFlag    = 1'b0;
      signFlag   = 1'b0;
      shiftFlag  = 1'b0;
      case (opcode)
         OP_REG: begin
            instrClass = CLASS_ALU_REG;
            case (ext)
               EXT_ADD: aluOp = ALU_ADD;
               EXT_SUB: aluOp = ALU_SUB;
               EXT_AND: aluOp = ALU_AND;
               EXT_OR:  aluOp = ALU_OR;
               EXT_XOR: aluOp = ALU_XOR;
               EXT_CMP: aluOp = ALU_CMP;
               EXT_MOV: aluOp = ALU_MOV;
               default: instrClass = CLASS_NOP;
            endcase
         end
         OP_MEM: begin
            if (ext == EXT_LOAD) begin
               instrClass = CLASS_LOAD;
            end else if (ext == EXT_STORE) begin
               instrClass = CLASS_STORE;
            end else begin
               instrClass = CLASS_ALU_IMM;
               aluOp      = ALU_OR;
               immFlag    = 1'b1;
            end
         end
         OP_ADDI: begin
            instrClass = CLASS_ALU_IMM;
            aluOp      = ALU_ADD;
            immFlag    = 1'b1;
            signFlag   = 1'b1;
         end
         OP_SUBI: begin
            instrClass = CLASS_ALU_IMM;
            aluOp      = ALU_SUB;
            immFlag    = 1'b1;
            signFlag   = 1'b1;
         end
         OP_ANDI: begin
            instrClass = CLASS_ALU_IMM;
            aluOp      = ALU_AND;
            immFlag    = 1'b1;
         end
         OP_XORI: begin
            instrClass = CLASS_ALU_IMM;
            aluOp      = ALU_XOR;
            immFlag    = 1'b1;
         end
         OP_CMPI: begin
            instrClass = CLASS_ALU_IMM;
            aluOp      = ALU_CMP;
            immFlag    = 1'b1;
            signFlag   = 1'b1;
         end
         OP_MOVI: begin
            instrClass = CLASS_ALU_IMM;
            aluOp      = ALU_MOV;
            immFlag    = 1'b1;
            signFlag   = 1'b1;
         end
         OP_SHIFT: begin
            if (ext == EXT_LSH) begin
               instrClass = CLASS_SHIFT;
               aluOp      = ALU_LSH;
               shiftFlag  = 1'b1;
            end else if (ext == EXT_LSHI || ext == EXT_LSHI_ALT) begin
               instrClass = CLASS_SHIFT;
               aluOp      = ALU_LSH;
               shiftFlag  = 1'b1;
               immFlag    = 1'b1;
               signFlag   = 1'b1;
            end
         end
         default: instrClass = CLASS_NOP;
      endcase
   end

endmodule

// File: rtl/state_machine.sv
// Multicycle control FSM for the 16-bit datapath. Outputs are registered:
// each edge loads them from the Moore decode of the state and IR being
// entered, so they always equal the decode of the current state and IR.
// After reset releases, the first edge arms the FSM and opens FETCH.
module state_machine
   import state_machine_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instruction,
   output logic [3:0]  aluControl,
   output logic [1:0]  pcRegEn,
   output logic [1:0]  srcRegEn,
   output logic [1:0]  dstRegEn,
   output logic [1:0]  immRegEn,
   output logic [1:0]  resultRegEn,
   output logic [1:0]  signEn,
   output logic [1:0]  regFileEn,
   output logic [1:0]  pcRegMuxEn,
   output logic [1:0]  mux4En,
   output logic [1:0]  shiftALUMuxEn,
   output logic [1:0]  regImmMuxEn,
   output logic        memread,
   output logic        memwrite,
   output logic        writedata
);

   stateType      state;
   stateType      nextState;
   logic          started;
   logic [15:0]   ir;
   logic [15:0]   nextIr;
   instrClassType decClass;
   logic [3:0]    decAlu;
   logic          decImm;
   logic          decSign;
   logic          decShift;

   logic [3:0]    nAlu;
   logic [1:0]    nPc, nSrc, nDst, nImm, nRes, nSign, nRf, nPcMux, nMux4, nShMux, nRiMux;
   logic          nMemread, nMemwrite, nWritedata;

   // IR only captures the bus on the edge that leaves an armed FETCH.
   assign nextIr = (started && state == FETCH) ? instruction : ir;

   instr_decode decoder (
      .ir         (nextIr),
      .instrClass (decClass),
      .aluOp      (decAlu),
      .immFlag    (decImm),
      .signFlag   (decSign),
      .shiftFlag  (decShift)
   );

   // Sequencing between states; DECODE branches on instruction class and
   // compares skip write-back.
   always_comb begin
      nextState = FETCH;
      if (started) begin
         case (state)
            FETCH:  nextState = DECODE;
            DECODE: begin
               case (decClass)
                  CLASS_ALU_REG,
                  CLASS_ALU_IMM,
                  CLASS_SHIFT:  nextState = EXEC;
                  CLASS_LOAD:   nextState = MEM_RD;
                  CLASS_STORE:  nextState = MEM_WR;
                  default:      nextState = FETCH;
               endcase
            end
            EXEC:   nextState = (decAlu == ALU_CMP) ? FETCH : WB;
            WB:     nextState = FETCH;
            MEM_RD: nextState = LD_WB;
            LD_WB:  nextState = FETCH;
            MEM_WR: nextState = FETCH;
            default: nextState = FETCH;
         endcase
      end
   end

   // Moore output decode of the state being entered; anything not named
   // for that state stays zero.
   always_comb begin
      nAlu       = ALU_ADD;
      nPc        = EN_OFF;
      nSrc       = EN_OFF;
      nDst       = EN_OFF;
      nImm       = EN_OFF;
      nRes       = EN_OFF;
      nSign      = EN_OFF;
      nRf        = EN_OFF;
      nPcMux     = ADDR_PC;
      nMux4      = WB_RESULT;
      nShMux     = RES_ALU;
      nRiMux     = B_SRC;
      nMemread   = 1'b0;
      nMemwrite  = 1'b0;
      nWritedata = 1'b0;
      case (nextState)
         FETCH: begin
            nMemread = 1'b1;
            nPcMux   = ADDR_PC;
            nPc      = EN_ON;
         end
         DECODE: begin
            nSrc  = EN_ON;
            nDst  = EN_ON;
            nImm  = EN_ON;
            nSign = enIf(decSign);
         end
         EXEC: begin
            nAlu   = decAlu;
            nRiMux = decImm ? B_IMM : B_SRC;
            nShMux = decShift ? RES_SHIFT : RES_ALU;
            nRes   = enIf(decAlu != ALU_CMP);
         end
         WB: begin
            nRf   = EN_ON;
            nMux4 = WB_RESULT;
         end
         MEM_RD: begin
            nMemread = 1'b1;
            nPcMux   = ADDR_SRC;
         end
         LD_WB: begin
            nRf   = EN_ON;
            nMux4 = WB_MEM;
         end
         MEM_WR: begin
            nMemwrite  = 1'b1;
            nWritedata = 1'b1;
            nPcMux     = ADDR_SRC;
         end
         default: begin
            nMemread = 1'b0;
         end
      endcase
   end

   // State, IR and registered outputs; reset aborts everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= FETCH;
         started       <= 1'b0;
         ir            <= '0;
         aluControl    <= '0;
         pcRegEn       <= '0;
         srcRegEn      <= '0;
         dstRegEn      <= '0;
         immRegEn      <= '0;
         resultRegEn   <= '0;
         signEn        <= '0;
         regFileEn     <= '0;
         pcRegMuxEn    <= '0;
         mux4En        <= '0;
         shiftALUMuxEn <= '0;
         regImmMuxEn   <= '0;
         memread       <= 1'b0;
         memwrite      <= 1'b0;
         writedata     <= 1'b0;
      end else begin
         state         <= nextState;
         started       <= 1'b1;
         ir            <= nextIr;
         aluControl    <= nAlu;
         pcRegEn       <= nPc;
         srcRegEn      <= nSrc;
         dstRegEn      <= nDst;
         immRegEn      <= nImm;
         resultRegEn   <= nRes;
         signEn        <= nSign;
         regFileEn     <= nRf;
         pcRegMuxEn    <= nPcMux;
         mux4En        <= nMux4;
         shiftALUMuxEn <= nShMux;
         regImmMuxEn   <= nRiMux;
         memread       <= nMemread;
         memwrite      <= nMemwrite;
         writedata     <= nWritedata;
      end
   end

endmodule

// File: tb/tb_state_machine.sv
// Directed self-checking bench for the multicycle control FSM.
module tb_state_machine;

   logic        clk;
   logic        reset;
   logic [15:0] instruction;
   logic [3:0]  aluControl;
   logic [1:0]  pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn, signEn;
   logic [1:0]  regFileEn, pcRegMuxEn, mux4En, shiftALUMuxEn, regImmMuxEn;
   logic        memread, memwrite, writedata;

   int testCount = 0;
   int failCount = 0;

   logic [28:0] obsVec;
   logic [28:0] eZero, eFetch, eDecZ, eDecS, eWb, eLdWb, eMemRd, eMemWr;

   state_machine dut (
      .clk           (clk),
      .reset         (reset),
      .instruction   (instruction),
      .aluControl    (aluControl),
      .pcRegEn       (pcRegEn),
      .srcRegEn      (srcRegEn),
      .dstRegEn      (dstRegEn),
      .immRegEn      (immRegEn),
      .resultRegEn   (resultRegEn),
      .signEn        (signEn),
      .regFileEn     (regFileEn),
      .pcRegMuxEn    (pcRegMuxEn),
      .mux4En        (mux4En),
      .shiftALUMuxEn (shiftALUMuxEn),
      .regImmMuxEn   (regImmMuxEn),
      .memread       (memread),
      .memwrite      (memwrite),
      .writedata     (writedata)
   );

   assign obsVec = {aluControl, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn,
                    signEn, regFileEn, pcRegMuxEn, mux4En, shiftALUMuxEn, regImmMuxEn,
                    memread, memwrite, writedata};

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [28:0] pack(
      input logic [3:0] alu, input logic [1:0] pc, input logic [1:0] src,
      input logic [1:0] dst, input logic [1:0] imm, input logic [1:0] res,
      input logic [1:0] sign, input logic [1:0] rf, input logic [1:0] pcMux,
      input logic [1:0] m4, input logic [1:0] sh, input logic [1:0] ri,
      input logic mr, input logic mw, input logic wd);
      return {alu, pc, src, dst, imm, res, sign, rf, pcMux, m4, sh, ri, mr, mw, wd};
   endfunction

   task automatic applyStimulus(input logic [15:0] word);
      instruction = word;
   endtask

   task automatic clockStep();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [28:0] expected);
      testCount++;
      assert (obsVec === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obsVec, expected);
      end
   endtask

   initial begin
      //               alu      pc     src    dst    imm    res    sign   rf     pcMux  m4     sh     ri    mr    mw    wd
      eZero  = '0;
      eFetch = pack(4'b0000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
      eDecZ  = pack(4'b0000, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      eDecS  = pack(4'b0000, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      eWb    = pack(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      eLdWb  = pack(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      eMemRd = pack(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
      eMemWr = pack(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);

      reset = 1'b1;
      applyStimulus(16'h2040);
      repeat (2) clockStep();
      checkOutput("reset_hold", eZero);
      @(negedge clk);
      reset = 1'b0;

      // STORE mem[R0] <= R0: F, D, MEM_WR, back to F
      clockStep(); checkOutput("st_fetch", eFetch);
      clockStep(); checkOutput("st_decode", eDecZ);
      applyStimulus(16'hFFFF);
      clockStep(); checkOutput("st_memwr", eMemWr);

      // ADD R1,R3 (ext 0101): 4 cycles
      clockStep(); checkOutput("add_fetch", eFetch);
      applyStimulus(16'h0153);
      clockStep(); checkOutput("add_decode", eDecZ);
      clockStep(); checkOutput("add_exec", pack(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      clockStep(); checkOutput("add_wb", eWb);

      // LOAD R1 <= mem[R3]
      clockStep(); checkOutput("ld_fetch", eFetch);
      applyStimulus(16'h2103);
      clockStep(); checkOutput("ld_decode", eDecZ);
      clockStep(); checkOutput("ld_memrd", eMemRd);
      clockStep(); checkOutput("ld_wb", eLdWb);

      // ADDI R1,#FF: sign-extended immediate, B operand from imm
      clockStep(); checkOutput("addi_fetch", eFetch);
      applyStimulus(16'h51FF);
      clockStep(); checkOutput("addi_decode", eDecS);
      clockStep(); checkOutput("addi_exec", pack(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0));
      clockStep(); checkOutput("addi_wb", eWb);

      // CMP R2,R1 (ext 1011): no result latch, no write-back, 3 cycles
      clockStep(); checkOutput("cmp_fetch", eFetch);
      applyStimulus(16'h02B1);
      clockStep(); checkOutput("cmp_decode", eDecZ);
      clockStep(); checkOutput("cmp_exec", pack(4'b0101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      clockStep(); checkOutput("cmp_next_fetch", eFetch);

      // 0x0B12 has ext 0001, which is AND
      applyStimulus(16'h0B12);
      clockStep(); checkOutput("and_decode", eDecZ);
      clockStep(); checkOutput("and_exec", pack(4'b0010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      clockStep(); checkOutput("and_wb", eWb);

      // CMPI R2,#05: signed immediate compare, 3 cycles
      clockStep(); checkOutput("cmpi_fetch", eFetch);
      applyStimulus(16'hB205);
      clockStep(); checkOutput("cmpi_decode", eDecS);
      clockStep(); checkOutput("cmpi_exec", pack(4'b0101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0));
      clockStep(); checkOutput("cmpi_next_fetch", eFetch);

      // LSHI R1,#3: shifter result, immediate B, signed
      applyStimulus(16'h8103);
      clockStep(); checkOutput("lshi_decode", eDecS);
      clockStep(); checkOutput("lshi_exec", pack(4'b0111, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0));
      clockStep(); checkOutput("lshi_wb", eWb);

      // LSH R1,R2: shifter result, register B
      clockStep(); checkOutput("lsh_fetch", eFetch);
      applyStimulus(16'h8142);
      clockStep(); checkOutput("lsh_decode", eDecZ);
      clockStep(); checkOutput("lsh_exec", pack(4'b0111, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0));
      clockStep(); checkOutput("lsh_wb", eWb);

      // Unknown opcode: NOP, F then D then back to F
      clockStep(); checkOutput("nop_fetch", eFetch);
      applyStimulus(16'hF000);
      clockStep(); checkOutput("nop_decode", eDecZ);
      clockStep(); checkOutput("nop_next_fetch", eFetch);

      // ADD again, reset asserted during EXEC
      applyStimulus(16'h0153);
      clockStep(); checkOutput("abort_decode", eDecZ);
      clockStep(); checkOutput("abort_exec", pack(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
      #2 reset = 1'b1;
      #1 checkOutput("abort_async_clear", eZero);
      clockStep(); checkOutput("abort_no_wb", eZero);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(16'hF000);
      clockStep(); checkOutput("abort_refetch", eFetch);
      clockStep(); checkOutput("abort_nop_decode", eDecZ);
      clockStep(); checkOutput("abort_nop_fetch", eFetch);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
